// File: rtl/line_cmd_dispatch_if.sv
// Bus bundle between the coordinate FIFOs, the line drawer and the
// line-command dispatcher. The dispatcher uses the master view; the
// FIFO/drawer side (or a bench) uses the slave view.
interface line_cmd_dispatch_if #(
  parameter int N  = 11,
  parameter int CH = 2
);
  // FIFO side
  logic [CH-1:0]   empty;
  logic [CH*N-1:0] in_x0;
  logic [CH*N-1:0] in_y0;
  logic [CH*N-1:0] in_x1;
  logic [CH*N-1:0] in_y1;
  logic [CH-1:0]   in_color;
  logic [CH-1:0]   rd;
  // control
  logic            clear_req;
  // drawer side
  logic            done;
  logic [N-1:0]    x0;
  logic [N-1:0]    y0;
  logic [N-1:0]    x1;
  logic [N-1:0]    y1;
  logic            color;
  logic            start;
  // status
  logic            busy;
  logic            clearing;

  modport master (
    input  empty, in_x0, in_y0, in_x1, in_y1, in_color, clear_req, done,
    output rd, x0, y0, x1, y1, color, start, busy, clearing
  );

  modport slave (
    output empty, in_x0, in_y0, in_x1, in_y1, in_color, clear_req, done,
    input  rd, x0, y0, x1, y1, color, start, busy, clearing
  );
endinterface

// File: rtl/line_cmd_dispatch.sv
// Line-command dispatcher: round-robin pops one endpoint set from CH
// coordinate FIFOs and hands it to the line drawer with a start/done
// handshake, one line in flight at a time. A frame clear (one colour-0
// horizontal line per screen row) takes priority over the FIFOs.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting; picks clear or next non-empty FIFO
// FETCH     | rd strobe high for the granted FIFO (single cycle)
// LATCH     | FIFO data valid; capture it and raise start
// BUSY      | line in flight; wait for done (ignored while start=1)
// CLR_ISSUE | drive row line (0,row)->(SCREEN_W-1,row), raise start
// CLR_BUSY  | clear line in flight; on done advance row or finish
module line_cmd_dispatch #(
  parameter int N        = 11,
  parameter int CH       = 2,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic              clock,
  input logic              reset,
  line_cmd_dispatch_if.master bus
);

  localparam int PW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [N-1:0] X_LAST = N'(SCREEN_W - 1);
  localparam logic [N-1:0] Y_LAST = N'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LATCH     = 3'd2,
    BUSY      = 3'd3,
    CLR_ISSUE = 3'd4,
    CLR_BUSY  = 3'd5
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gsel;
  logic [N-1:0]  row;
  logic          pending;

  logic          grant_ok;
  logic [PW-1:0] grant_idx;
  logic          clear_go;

  // First non-empty channel at or after the round-robin pointer.
  always_comb begin
    int cand;
    cand      = 0;
    grant_ok  = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < CH; k++) begin
      cand = int'(ptr) + k;
      if (cand >= CH) cand = cand - CH;
      if (!grant_ok && !bus.empty[cand[PW-1:0]]) begin
        grant_ok  = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
  end

  // A request arriving in the IDLE cycle itself must still beat a
  // waiting FIFO entry, so the raw request is looked at alongside the flag.
  assign clear_go = pending | bus.clear_req;

  // Dispatcher FSM with all drawer/FIFO outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      gsel         <= '0;
      row          <= '0;
      pending      <= 1'b0;
      bus.rd       <= '0;
      bus.x0       <= '0;
      bus.y0       <= '0;
      bus.x1       <= '0;
      bus.y1       <= '0;
      bus.color    <= 1'b0;
      bus.start    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.clearing <= 1'b0;
    end else begin
      if (bus.clear_req) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (clear_go) begin
            pending      <= 1'b0;
            row          <= '0;
            bus.clearing <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= CLR_ISSUE;
          end else if (grant_ok) begin
            bus.rd   <= CH'(1) << grant_idx;
            gsel     <= grant_idx;
            ptr      <= (grant_idx == PW'(CH - 1)) ? '0 : grant_idx + 1'b1;
            bus.busy <= 1'b1;
            state    <= FETCH;
          end
        end

        FETCH: begin
          bus.rd <= '0;
          state  <= LATCH;
        end

        LATCH: begin
          bus.x0    <= bus.in_x0[int'(gsel)*N +: N];
          bus.y0    <= bus.in_y0[int'(gsel)*N +: N];
          bus.x1    <= bus.in_x1[int'(gsel)*N +: N];
          bus.y1    <= bus.in_y1[int'(gsel)*N +: N];
          bus.color <= bus.in_color[gsel];
          bus.start <= 1'b1;
          state     <= BUSY;
        end

        BUSY: begin
          bus.start <= 1'b0;
          if (!bus.start && bus.done) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        CLR_ISSUE: begin
          bus.x0    <= '0;
          bus.y0    <= row;
          bus.x1    <= X_LAST;
          bus.y1    <= row;
          bus.color <= 1'b0;
          bus.start <= 1'b1;
          state     <= CLR_BUSY;
        end

        CLR_BUSY: begin
          bus.start <= 1'b0;
          if (!bus.start && bus.done) begin
            if (row == Y_LAST) begin
              bus.busy     <= 1'b0;
              bus.clearing <= 1'b0;
              state        <= IDLE;
            end else begin
              row   <= row + 1'b1;
              state <= CLR_ISSUE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_cmd_dispatch.sv
// Directed bench for line_cmd_dispatch: registered-read FIFO model per
// channel, a drawer model returning done, and immediate assertions.
module tb_line_cmd_dispatch;
  localparam int N  = 11;
  localparam int CH = 2;
  localparam int W  = 640;
  localparam int H  = 4;

  typedef struct packed {
    logic [N-1:0] x0;
    logic [N-1:0] y0;
    logic [N-1:0] x1;
    logic [N-1:0] y1;
    logic         color;
  } entry_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  line_cmd_dispatch_if #(.N(N), .CH(CH)) bus ();

  line_cmd_dispatch #(.N(N), .CH(CH), .SCREEN_W(W), .SCREEN_H(H)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  entry_t q0[$];
  entry_t q1[$];
  logic [CH-1:0]  rd_log[$];
  logic [4*N+1:0] st_log[$];   // {entry, clearing at start}
  int rd_count     = 0;
  int rd_while_clr = 0;
  int bad_rd       = 0;

  logic auto_done   = 1'b0;
  logic manual_done = 1'b0;
  int   auto_cnt    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t mk(input int a, input int b, input int c, input int d, input logic col);
    entry_t e;
    e.x0 = N'(a); e.y0 = N'(b); e.x1 = N'(c); e.y1 = N'(d); e.color = col;
    return e;
  endfunction

  task automatic update_empty();
    bus.empty = {(q1.size() == 0), (q0.size() == 0)};
  endtask

  task automatic set_ch_data(input int ch, input entry_t e);
    bus.in_x0[ch*N +: N] = e.x0;
    bus.in_y0[ch*N +: N] = e.y0;
    bus.in_x1[ch*N +: N] = e.x1;
    bus.in_y1[ch*N +: N] = e.y1;
    bus.in_color[ch]     = e.color;
  endtask

  task automatic push(input int ch, input entry_t e);
    if (ch == 0) q0.push_back(e); else q1.push_back(e);
    update_empty();
  endtask

  // FIFO model: rd seen during a cycle pops at the following edge.
  initial begin
    logic [CH-1:0] rd_s;
    bus.empty = '1;
    bus.in_x0 = '0; bus.in_y0 = '0; bus.in_x1 = '0; bus.in_y1 = '0;
    bus.in_color = '0;
    forever begin
      @(negedge clock);
      rd_s = bus.rd;
      @(posedge clock);
      #1;
      if (rd_s[0] && q0.size() > 0) set_ch_data(0, q0.pop_front());
      if (rd_s[1] && q1.size() > 0) set_ch_data(1, q1.pop_front());
      update_empty();
    end
  end

  // Drawer model: auto mode returns done two cycles after start.
  initial begin
    bus.done = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (auto_done) begin
        if (auto_cnt > 0) begin
          auto_cnt--;
          bus.done = (auto_cnt == 0);
        end else begin
          bus.done = 1'b0;
          if (bus.start) auto_cnt = 2;
        end
      end else begin
        bus.done = manual_done;
      end
    end
  end

  // Event recorder for rd pulses and start pulses.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.rd != '0) begin
        rd_count++;
        rd_log.push_back(bus.rd);
        if (bus.clearing) rd_while_clr++;
        if ((bus.rd & bus.empty) != '0 || !$onehot(bus.rd)) bad_rd++;
      end
      if (bus.start) st_log.push_back({bus.x0, bus.y0, bus.x1, bus.y1, bus.color, bus.clearing});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [CH-1:0] exp_rd;

    bus.clear_req = 1'b0;

    // ---- 1: reset, all outputs zero
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("t1_outs", 64'({bus.rd, bus.start, bus.busy, bus.clearing, bus.x0, bus.y0, bus.x1, bus.y1, bus.color}), 64'(0));
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("t1_rd_cnt", 64'(rd_count), 64'(0));
    check("t1_st_cnt", 64'(st_log.size()), 64'(0));
    check("t1_busy", 64'(bus.busy), 64'(0));

    // ---- 2: single entry on ch0, exact latency
    push(0, mk(10, 20, 30, 40, 1'b1));          // cycle 0
    @(negedge clock);                           // cycle 1
    check("t2_rd_c1", 64'(bus.rd), 64'(2'b01));
    check("t2_busy_c1", 64'(bus.busy), 64'(1));
    @(negedge clock);                           // cycle 2
    check("t2_rd_c2", 64'(bus.rd), 64'(0));
    check("t2_start_c2", 64'(bus.start), 64'(0));
    @(negedge clock);                           // cycle 3
    check("t2_start_c3", 64'(bus.start), 64'(1));
    check("t2_line", 64'({bus.x0, bus.y0, bus.x1, bus.y1, bus.color}), 64'(mk(10, 20, 30, 40, 1'b1)));
    repeat (5) @(negedge clock);
    check("t2_busy_hold", 64'(bus.busy), 64'(1));
    check("t2_start_once", 64'(bus.start), 64'(0));
    manual_done = 1'b1;
    @(negedge clock);
    manual_done = 1'b0;
    @(negedge clock);
    check("t2_busy_end", 64'(bus.busy), 64'(0));
    check("t2_rd_cnt", 64'(rd_count), 64'(1));
    check("t2_st_cnt", 64'(st_log.size()), 64'(1));
    check("t2_hold", 64'({bus.x0, bus.y0, bus.x1, bus.y1, bus.color}), 64'(mk(10, 20, 30, 40, 1'b1)));

    // ---- 3: round robin over both channels, pointer back at 0
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rd_log.delete(); st_log.delete(); rd_count = 0;
    auto_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(0, mk(100 + i, 200 + i, 300 + i, 400 + i, 1'b1));
      push(1, mk(500 + i, 600 + i, 700 + i, 800 + i, 1'b0));
    end
    for (int i = 0; i < 300 && !(st_log.size() >= 6 && !bus.busy); i++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("t3_st_cnt", 64'(st_log.size()), 64'(6));
    check("t3_rd_cnt", 64'(rd_count), 64'(6));
    for (int i = 0; i < 6 && i < rd_log.size(); i++) begin
      exp_rd = (i % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("t3_grant%0d", i), 64'(rd_log[i]), 64'(exp_rd));
    end
    for (int i = 0; i < 6 && i < st_log.size(); i++) begin
      if (i % 2 == 0)
        check($sformatf("t3_line%0d", i), 64'(st_log[i]), 64'({mk(100 + i/2, 200 + i/2, 300 + i/2, 400 + i/2, 1'b1), 1'b0}));
      else
        check($sformatf("t3_line%0d", i), 64'(st_log[i]), 64'({mk(500 + i/2, 600 + i/2, 700 + i/2, 800 + i/2, 1'b0), 1'b0}));
    end

    // ---- 4: clear wins over a waiting ch0 entry
    base = st_log.size();
    rd_while_clr = 0;
    push(0, mk(5, 6, 7, 8, 1'b1));
    bus.clear_req = 1'b1;
    @(negedge clock);
    bus.clear_req = 1'b0;
    check("t4_clearing", 64'(bus.clearing), 64'(1));
    check("t4_no_rd", 64'(bus.rd), 64'(0));
    for (int i = 0; i < 300 && !(st_log.size() >= base + 5 && !bus.busy); i++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("t4_st_cnt", 64'(st_log.size() - base), 64'(5));
    for (int y = 0; y < H && base + y < st_log.size(); y++)
      check($sformatf("t4_row%0d", y), 64'(st_log[base + y]), 64'({mk(0, y, W - 1, y, 1'b0), 1'b1}));
    if (st_log.size() > base + 4)
      check("t4_after", 64'(st_log[base + 4]), 64'({mk(5, 6, 7, 8, 1'b1), 1'b0}));
    check("t4_rd_in_clr", 64'(rd_while_clr), 64'(0));
    check("t4_clearing_end", 64'(bus.clearing), 64'(0));

    // ---- 5: clear requested during a clear runs a second full clear
    base = st_log.size();
    bus.clear_req = 1'b1;
    @(negedge clock);
    bus.clear_req = 1'b0;
    repeat (5) @(negedge clock);
    check("t5_mid_clearing", 64'(bus.clearing), 64'(1));
    bus.clear_req = 1'b1;
    @(negedge clock);
    bus.clear_req = 1'b0;
    for (int i = 0; i < 300 && !(st_log.size() >= base + 8 && !bus.busy); i++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("t5_st_cnt", 64'(st_log.size() - base), 64'(8));
    for (int k = 0; k < 8 && base + k < st_log.size(); k++)
      check($sformatf("t5_line%0d", k), 64'(st_log[base + k]), 64'({mk(0, k % H, W - 1, k % H, 1'b0), 1'b1}));
    check("t5_idle", 64'({bus.busy, bus.clearing}), 64'(0));

    // ---- 6: reset while BUSY, then reset while an entry is popped
    auto_done = 1'b0;
    manual_done = 1'b0;
    push(1, mk(11, 22, 33, 44, 1'b1));
    for (int i = 0; i < 20 && !bus.start; i++) @(negedge clock);
    check("t6_started", 64'(bus.start), 64'(1));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_outs", 64'({bus.rd, bus.start, bus.busy, bus.clearing, bus.x0, bus.y0, bus.x1, bus.y1, bus.color}), 64'(0));
    reset = 1'b0;
    base = st_log.size();
    push(0, mk(9, 9, 9, 9, 1'b1));
    for (int i = 0; i < 20 && bus.rd == '0; i++) @(negedge clock);
    check("t6_rd", 64'(bus.rd), 64'(2'b01));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("t6_no_start", 64'(st_log.size() - base), 64'(0));
    check("t6_idle", 64'({bus.busy, bus.x0}), 64'(0));
    check("t6_bad_rd", 64'(bad_rd), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
